// File: rtl/uart_mem_leaf.sv
// uart_mem_leaf: serial receiver, serial transmitter and a word-addressed RAM.
// The three blocks share clk/rst only; the surrounding command FSM wires them together.
module uart_mem_leaf #(
  parameter int unsigned FRAME_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH  = 4,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned BAUD_PERIOD = 16
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         rx,
  output logic [FRAME_WIDTH-1:0]                       rx_data,
  output logic                                         rx_done,
  input  logic                                         clr_rx_done,
  output logic                                         tx,
  input  logic                                         trmt,
  input  logic [FRAME_WIDTH-1:0]                       tx_data,
  output logic                                         tx_done,
  input  logic                                         clr_tx_done,
  input  logic                                         wr,
  input  logic [ADDR_WIDTH-1:0]                        addr,
  input  logic [DATA_WIDTH-1:0]                        wdata,
  output logic [DATA_WIDTH-1:0]                        rdata,
  output logic [(2**ADDR_WIDTH)-1:0][DATA_WIDTH-1:0]   mem_debug
);

  localparam int unsigned DEPTH = 2**ADDR_WIDTH;
  localparam int unsigned CNT_W = $clog2(BAUD_PERIOD);
  localparam int unsigned BIT_W = (FRAME_WIDTH > 1) ? $clog2(FRAME_WIDTH) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_PERIOD - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_PERIOD / 2 - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(FRAME_WIDTH - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} uart_state_e;

  // ---------------- receiver ----------------
  logic                   rx_meta_q, rx_sync_q, rx_prev_q;
  uart_state_e            rx_state_q, rx_state_d;
  logic [CNT_W-1:0]       rx_cnt_q, rx_cnt_d;
  logic [BIT_W-1:0]       rx_bit_q, rx_bit_d;
  logic [FRAME_WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [FRAME_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                   rx_done_q, rx_done_d;

  // Synchronizer plus one history flop for falling-edge detection; idles high.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_q <= ST_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_done_q  <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_done_q  <= rx_done_d;
    end
  end

  // Set of rx_done is assigned after the clear so that set wins.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + CNT_W'(1);
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_done_d  = rx_done_q & ~clr_rx_done;
    case (rx_state_q)
      ST_IDLE: begin
        rx_cnt_d = '0;
        if (rx_prev_q && !rx_sync_q) rx_state_d = ST_START;
      end
      ST_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_sync_q ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (rx_cnt_q == BAUD_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[FRAME_WIDTH-1:1]};
          rx_bit_d   = rx_bit_q + BIT_W'(1);
          if (rx_bit_q == BIT_LAST) rx_state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (rx_cnt_q == BAUD_LAST) begin
          rx_cnt_d   = '0;
          rx_state_d = ST_IDLE;
          if (rx_sync_q) begin
            rx_data_d = rx_shift_q;
            rx_done_d = 1'b1;
          end
        end
      end
      default: rx_state_d = ST_IDLE;
    endcase
  end

  assign rx_data = rx_data_q;
  assign rx_done = rx_done_q;

  // ---------------- transmitter ----------------
  uart_state_e            tx_state_q, tx_state_d;
  logic [CNT_W-1:0]       tx_cnt_q, tx_cnt_d;
  logic [BIT_W-1:0]       tx_bit_q, tx_bit_d;
  logic [FRAME_WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic                   tx_q, tx_d;
  logic                   tx_done_q, tx_done_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= ST_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
      tx_done_q  <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_q       <= tx_d;
      tx_done_q  <= tx_done_d;
    end
  end

  // Line level is registered: each bit value is loaded on the edge that starts it.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + CNT_W'(1);
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_d       = tx_q;
    tx_done_d  = tx_done_q & ~clr_tx_done;
    case (tx_state_q)
      ST_IDLE: begin
        tx_cnt_d = '0;
        if (trmt && !tx_done_q) begin
          tx_shift_d = tx_data;
          tx_d       = 1'b0;
          tx_state_d = ST_START;
        end
      end
      ST_START: begin
        if (tx_cnt_q == BAUD_LAST) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_d       = tx_shift_q[0];
          tx_state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (tx_cnt_q == BAUD_LAST) begin
          tx_cnt_d = '0;
          if (tx_bit_q == BIT_LAST) begin
            tx_d       = 1'b1;
            tx_state_d = ST_STOP;
          end else begin
            tx_bit_d   = tx_bit_q + BIT_W'(1);
            tx_shift_d = tx_shift_q >> 1;
            tx_d       = tx_shift_d[0];
          end
        end
      end
      ST_STOP: begin
        if (tx_cnt_q == BAUD_LAST) begin
          tx_cnt_d   = '0;
          tx_done_d  = 1'b1;
          tx_state_d = ST_IDLE;
        end
      end
      default: tx_state_d = ST_IDLE;
    endcase
  end

  assign tx      = tx_q;
  assign tx_done = tx_done_q;

  // ---------------- RAM ----------------
  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '0;
    end else if (wr) begin
      mem_q[addr] <= wdata;
    end
  end

  assign rdata     = mem_q[addr];
  assign mem_debug = mem_q;

endmodule

// File: tb/tb_uart_mem_leaf.sv
// tb_uart_mem_leaf: scoreboard bench; expected RX/TX frames are queued at stimulus
// time and retired by line/flag monitors, RAM checked against a local model.
module tb_uart_mem_leaf;

  localparam int unsigned FW   = 8;
  localparam int unsigned AW   = 4;
  localparam int unsigned DW   = 8;
  localparam int unsigned BAUD = 16;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               rx;
  logic               rx_drv = 1'b1;
  logic               loop_en = 1'b0;
  logic [FW-1:0]      rx_data;
  logic               rx_done;
  logic               clr_rx_done = 1'b0;
  logic               tx;
  logic               trmt = 1'b0;
  logic [FW-1:0]      tx_data = '0;
  logic               tx_done;
  logic               clr_tx_done = 1'b0;
  logic               wr = 1'b0;
  logic [AW-1:0]      addr = '0;
  logic [DW-1:0]      wdata = '0;
  logic [DW-1:0]      rdata;
  logic [(2**AW)-1:0][DW-1:0] mem_debug;

  int                 n_checks = 0;
  int                 n_pass = 0;
  int                 cyc = 0;
  int                 rx_t0 = 0;
  int                 rx_done_cyc = 0;
  int                 tx_fall_cyc = 0;
  logic [FW-1:0]      rx_q[$];
  logic [FW-1:0]      tx_q[$];
  logic [DW-1:0]      mem_m [2**AW];

  assign rx = loop_en ? tx : rx_drv;

  uart_mem_leaf #(
    .FRAME_WIDTH(FW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BAUD_PERIOD(BAUD)
  ) dut (
    .clk(clk), .rst(rst), .rx(rx), .rx_data(rx_data), .rx_done(rx_done),
    .clr_rx_done(clr_rx_done), .tx(tx), .trmt(trmt), .tx_data(tx_data),
    .tx_done(tx_done), .clr_tx_done(clr_tx_done), .wr(wr), .addr(addr),
    .wdata(wdata), .rdata(rdata), .mem_debug(mem_debug)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One frame on rx; also clears the previous rx_done during the start bit.
  task automatic send_rx(input logic [FW-1:0] d, input logic stop_bit, input bit push);
    if (push) rx_q.push_back(d);
    rx_t0       = cyc;
    rx_drv      = 1'b0;
    clr_rx_done = 1'b1;
    tick(1);
    clr_rx_done = 1'b0;
    tick(BAUD - 1);
    for (int i = 0; i < FW; i++) begin
      rx_drv = d[i];
      tick(BAUD);
    end
    rx_drv = stop_bit;
    tick(BAUD);
    rx_drv = 1'b1;
  endtask

  task automatic wait_tx_done(input int lim);
    int n;
    n = 0;
    while (!tx_done && n < lim) begin
      tick(1);
      n++;
    end
    chk("tx_done_wait", 128'(tx_done), 128'(1));
  endtask

  // rx_done rising edge retires one expected frame.
  initial begin : rx_mon
    logic prev;
    logic [FW-1:0] e;
    prev = 1'b0;
    forever begin
      tick(1);
      if (rx_done && !prev) begin
        rx_done_cyc = cyc;
        if (rx_q.size() == 0) chk("rx_unexpected_done", 128'(1), 128'(0));
        else begin
          e = rx_q.pop_front();
          chk("rx_data", 128'(rx_data), 128'(e));
        end
      end
      prev = rx_done;
    end
  end

  // Decodes tx at bit centres and checks frame timing against tx_done.
  initial begin : tx_mon
    logic prev;
    logic [FW-1:0] b;
    logic [FW-1:0] e;
    prev = 1'b1;
    forever begin
      tick(1);
      if (prev && !tx) begin
        tx_fall_cyc = cyc;
        tick(BAUD / 2);
        chk("tx_start_bit", 128'(tx), 128'(0));
        for (int i = 0; i < FW; i++) begin
          tick(BAUD);
          b[i] = tx;
        end
        tick(BAUD);
        chk("tx_stop_bit", 128'(tx), 128'(1));
        tick(BAUD / 2 - 1);
        chk("tx_done_early", 128'(tx_done), 128'(0));
        tick(1);
        chk("tx_done_at_160", 128'(tx_done), 128'(1));
        if (tx_q.size() == 0) chk("tx_unexpected_frame", 128'(1), 128'(0));
        else begin
          e = tx_q.pop_front();
          chk("tx_byte", 128'(b), 128'(e));
        end
      end
      prev = tx;
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [AW-1:0] wa [3];
    logic [DW-1:0] wd [3];
    int t0;
    int lat;
    wa = '{4'd0, 4'd5, 4'd15};
    wd = '{8'h11, 8'h22, 8'hEE};
    for (int i = 0; i < 2**AW; i++) mem_m[i] = '0;

    // reset
    tick(2);
    rst = 1'b0;
    chk("rst_tx", 128'(tx), 128'(1));
    chk("rst_rx_done", 128'(rx_done), 128'(0));
    chk("rst_tx_done", 128'(tx_done), 128'(0));
    chk("rst_rx_data", 128'(rx_data), 128'(0));
    chk("rst_mem", 128'(mem_debug), 128'(0));
    tick(3);

    // good frame, latency, clear
    send_rx(8'hA5, 1'b1, 1'b1);
    lat = rx_done_cyc - rx_t0;
    chk("rx_latency_in_154pm1", 128'((lat >= 153) && (lat <= 155)), 128'(1));
    chk("rx_done_set", 128'(rx_done), 128'(1));
    clr_rx_done = 1'b1;
    tick(1);
    clr_rx_done = 1'b0;
    chk("rx_done_cleared", 128'(rx_done), 128'(0));
    chk("rx_data_held", 128'(rx_data), 128'(8'hA5));

    // false start glitch
    rx_drv = 1'b0;
    tick(4);
    rx_drv = 1'b1;
    tick(200);
    chk("glitch_no_done", 128'(rx_done), 128'(0));

    // framing error
    send_rx(8'h3C, 1'b0, 1'b0);
    tick(20);
    chk("frame_err_no_done", 128'(rx_done), 128'(0));
    chk("frame_err_data_held", 128'(rx_data), 128'(8'hA5));

    // back-to-back frames, zero idle gap
    send_rx(8'h96, 1'b1, 1'b1);
    send_rx(8'($urandom_range(0, 255)), 1'b1, 1'b1);
    tick(10);

    // reset mid-frame: the rest of 0xFF leaves the line high
    fork
      send_rx(8'hFF, 1'b1, 1'b0);
      begin
        tick(60);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
      end
    join
    tick(20);
    chk("midrst_no_done", 128'(rx_done), 128'(0));
    chk("midrst_rx_data", 128'(rx_data), 128'(0));

    // transmit 0x5A with trmt held high
    tx_data = 8'h5A;
    tx_q.push_back(8'h5A);
    trmt = 1'b1;
    t0 = cyc;
    wait_tx_done(400);
    chk("tx_latency", 128'(tx_fall_cyc - t0), 128'(1));
    tick(48);
    chk("tx_hold_while_done", 128'(tx), 128'(1));
    chk("tx_done_sticky", 128'(tx_done), 128'(1));
    tx_data = 8'hC3;
    tx_q.push_back(8'hC3);
    clr_tx_done = 1'b1;
    t0 = cyc;
    tick(1);
    clr_tx_done = 1'b0;
    wait_tx_done(400);
    chk("tx_restart_latency", 128'(tx_fall_cyc - t0), 128'(2));
    trmt = 1'b0;
    clr_tx_done = 1'b1;
    clr_rx_done = 1'b1;
    tick(1);
    clr_tx_done = 1'b0;
    clr_rx_done = 1'b0;
    tick(5);

    // loopback tx -> rx
    loop_en = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tx_data = (k == 0) ? 8'hFF : 8'h00;
      tx_q.push_back(tx_data);
      rx_q.push_back(tx_data);
      trmt = 1'b1;
      tick(1);
      trmt = 1'b0;
      wait_tx_done(400);
      tick(2);
      chk("loop_rx_done", 128'(rx_done), 128'(1));
      clr_tx_done = 1'b1;
      clr_rx_done = 1'b1;
      tick(1);
      clr_tx_done = 1'b0;
      clr_rx_done = 1'b0;
      tick(5);
    end
    loop_en = 1'b0;

    // RAM writes: rdata shows the old word until the write edge
    for (int i = 0; i < 3; i++) begin
      addr  = wa[i];
      wdata = wd[i];
      wr    = 1'b1;
      #1;
      chk("ram_old_before_edge", 128'(rdata), 128'(mem_m[wa[i]]));
      tick(1);
      wr = 1'b0;
      mem_m[wa[i]] = wd[i];
      chk("ram_rdata_after_write", 128'(rdata), 128'(wd[i]));
    end
    for (int a = 0; a < 2**AW; a++) begin
      addr = AW'(a);
      #1;
      chk("ram_rdata", 128'(rdata), 128'(mem_m[a]));
      chk("ram_mem_debug", 128'(mem_debug[a]), 128'(mem_m[a]));
    end

    // write during reset has no effect
    @(posedge clk);
    #1;
    rst   = 1'b1;
    wr    = 1'b1;
    addr  = 4'd7;
    wdata = 8'h77;
    tick(1);
    rst = 1'b0;
    wr  = 1'b0;
    #1;
    chk("rst_wr_blocked", 128'(rdata), 128'(0));
    chk("rst_mem_clear", 128'(mem_debug), 128'(0));

    tick(5);
    chk("rx_queue_drained", 128'(rx_q.size()), 128'(0));
    chk("tx_queue_drained", 128'(tx_q.size()), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
